// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types for the MEM stage: instruction type codes,
//               FSM state encoding and byte-count / alignment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam int INST_TYPE_W = 8;
  typedef logic [INST_TYPE_W-1:0] inst_type_t;

  localparam inst_type_t INST_LB  = 8'h20;
  localparam inst_type_t INST_LH  = 8'h21;
  localparam inst_type_t INST_LW  = 8'h23;
  localparam inst_type_t INST_LBU = 8'h24;
  localparam inst_type_t INST_LHU = 8'h25;
  localparam inst_type_t INST_SB  = 8'h28;
  localparam inst_type_t INST_SH  = 8'h29;
  localparam inst_type_t INST_SW  = 8'h2B;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Index of the last byte of the access (byte count minus one).
  function automatic logic [1:0] last_byte(input inst_type_t t);
    logic [1:0] n;
    case (t)
      INST_LB, INST_LBU, INST_SB: n = 2'd0;
      INST_LH, INST_LHU, INST_SH: n = 2'd1;
      default:                    n = 2'd3;
    endcase
    return n;
  endfunction

  function automatic logic is_misaligned(input inst_type_t t, input logic [1:0] a);
    logic m;
    case (t)
      INST_LH, INST_LHU, INST_SH: m = a[0];
      INST_LW, INST_SW:           m = (a != 2'b00);
      default:                    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_if.sv
// ============================================================================
// Module      : mem_access_if
// Description : Byte-wide RAM port. The MEM stage is the master; the RAM
//               returns read data one cycle after the address it was given.
//   ram_addr_out  ADDR_W  byte address
//   ram_wr_out    1       1 = write, 0 = read
//   ram_data_out  8       write byte
//   ram_data_in   8       read byte
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ram_addr_out;
  logic              ram_wr_out;
  logic [7:0]        ram_data_out;
  logic [7:0]        ram_data_in;

  modport master (output ram_addr_out, ram_wr_out, ram_data_out, input ram_data_in);
  modport slave  (input ram_addr_out, ram_wr_out, ram_data_out, output ram_data_in);
endinterface

`default_nettype wire

// File: rtl/mem_access_load_ext.sv
// ============================================================================
// Module      : mem_access_load_ext
// Description : Sign/zero extension of assembled load data.
//   inst_type_i  instruction code of the load
//   raw_i        little-endian assembled bytes
//   ext_o        extended write-back value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_load_ext
  import mem_access_pkg::*;
(
  input  inst_type_t  inst_type_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (inst_type_i)
      INST_LB:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      INST_LBU: ext_o = {24'h0, raw_i[7:0]};
      INST_LH:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      INST_LHU: ext_o = {16'h0, raw_i[15:0]};
      default:  ext_o = raw_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Pipeline MEM stage. Runs loads/stores as byte-serial
//               transactions on an 8-bit RAM port, stalling the pipeline
//               meanwhile; non-memory results pass straight through.
//               Optional macro MEM_ALIGN_CHECK_EN: misaligned H/W accesses
//               skip the RAM and raise misalign_out in DONE.
//   clk_in / rst_in (async, active-low) / rdy_in (low freezes the block)
//   rd_*_in, inst_type_in, load_in, store_in, mem_addr_in, mem_val_in : EX
//   rd_out, rd_addr_out, rd_val_out                                   : WB
//   stallreq_from_mem, misalign_out ; ram : RAM port (master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         rd_in,
  input  logic [4:0]   rd_addr_in,
  input  logic [31:0]  rd_val_in,
  input  inst_type_t   inst_type_in,
  input  logic         load_in,
  input  logic         store_in,
  input  logic [31:0]  mem_addr_in,
  input  logic [31:0]  mem_val_in,
  output logic         rd_out,
  output logic [4:0]   rd_addr_out,
  output logic [31:0]  rd_val_out,
  output logic         stallreq_from_mem,
  output logic         misalign_out,
  mem_access_if.master ram
);

  mem_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] buf_q, buf_d;
  inst_type_t  type_q, type_d;
  logic        is_load_q, is_load_d;
  logic        rd_q, rd_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        w_mis;

  logic        w_req;
  logic [1:0]  w_last;
  logic [1:0]  w_off;
  logic        w_addr_en;
  logic [31:0] w_sum;
  logic [31:0] w_ext;

  assign w_req  = load_in | store_in;
  assign w_last = last_byte(type_q);
  assign w_sum  = addr_q + {30'd0, w_off};

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign w_mis = mis_q;
`else
  assign w_mis = 1'b0;
`endif

  mem_access_load_ext u_load_ext (
    .inst_type_i (type_q),
    .raw_i       (buf_q),
    .ext_o       (w_ext)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= ZERO_WORD;
      data_q    <= ZERO_WORD;
      buf_q     <= ZERO_WORD;
      type_q    <= '0;
      is_load_q <= 1'b0;
      rd_q      <= 1'b0;
      rd_addr_q <= 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      buf_q     <= buf_d;
      type_q    <= type_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      rd_addr_q <= rd_addr_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Next state and RAM port. Every register update is gated by rdy_in so a
  // low rdy_in freezes the whole transaction.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    data_d           = data_q;
    buf_d            = buf_q;
    type_d           = type_q;
    is_load_d        = is_load_q;
    rd_d             = rd_q;
    rd_addr_d        = rd_addr_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d            = mis_q;
`endif
    w_off            = cnt_q;
    w_addr_en        = 1'b0;
    ram.ram_wr_out   = 1'b0;
    ram.ram_data_out = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (rdy_in && w_req) begin
          addr_d    = mem_addr_in;
          data_d    = mem_val_in;
          type_d    = inst_type_in;
          is_load_d = load_in;
          rd_d      = rd_in;
          rd_addr_d = rd_addr_in;
          cnt_d     = 2'd0;
          buf_d     = ZERO_WORD;
          state_d   = ST_XFER;
`ifdef MEM_ALIGN_CHECK_EN
          mis_d = is_misaligned(inst_type_in, mem_addr_in[1:0]);
          if (mis_d) state_d = ST_DONE;
`endif
        end
      end
      ST_XFER: begin
        w_addr_en = 1'b1;
        if (is_load_q) begin
          // The byte arriving now is lost while frozen; point the RAM back at
          // it so it arrives again in the first cycle after rdy_in returns.
          if (!rdy_in && cnt_q != 2'd0) w_off = cnt_q - 2'd1;
        end else begin
          ram.ram_wr_out   = rdy_in;
          ram.ram_data_out = data_q[{cnt_q, 3'b000} +: 8];
        end
        if (rdy_in) begin
          if (is_load_q && cnt_q != 2'd0)
            buf_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram.ram_data_in;
          if (cnt_q == w_last) state_d = is_load_q ? ST_WAIT : ST_DONE;
          else                 cnt_d   = cnt_q + 2'd1;
        end
      end
      ST_WAIT: begin
        if (rdy_in) begin
          buf_d[{w_last, 3'b000} +: 8] = ram.ram_data_in;
          state_d = ST_DONE;
        end else begin
          // Re-fetch the final byte while frozen (read only, no side effect).
          w_addr_en = 1'b1;
          w_off     = w_last;
        end
      end
      ST_DONE: begin
        if (rdy_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ram.ram_addr_out = w_addr_en ? ADDR_W'(w_sum) : '0;
  end

  // Write-back outputs and stall.
  always_comb begin
    rd_out            = 1'b0;
    rd_addr_out       = 5'd0;
    rd_val_out        = ZERO_WORD;
    misalign_out      = 1'b0;
    stallreq_from_mem = w_req & (state_q != ST_DONE);
    if (rst_in) begin
      case (state_q)
        ST_IDLE: begin
          if (!w_req) begin
            rd_out      = rd_in;
            rd_addr_out = rd_addr_in;
            rd_val_out  = rd_val_in;
          end
        end
        ST_DONE: begin
          rd_addr_out  = rd_addr_q;
          misalign_out = w_mis;
          if (is_load_q && !w_mis) begin
            rd_out     = rd_q;
            rd_val_out = w_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access with a byte RAM model,
//               a RAM write log and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;
  import mem_access_pkg::*;

  localparam inst_type_t INST_ADDI = 8'h01;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rd_in = 1'b0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic [31:0] rd_val_in = 32'd0;
  inst_type_t  inst_type_in = INST_ADDI;
  logic        load_in = 1'b0;
  logic        store_in = 1'b0;
  logic [31:0] mem_addr_in = 32'd0;
  logic [31:0] mem_val_in = 32'd0;
  logic        rd_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_val_out;
  logic        stallreq_from_mem;
  logic        misalign_out;

  mem_access_if #(.ADDR_W(32)) ram_if ();

  mem_access #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_in(rd_in), .rd_addr_in(rd_addr_in), .rd_val_in(rd_val_in),
    .inst_type_in(inst_type_in), .load_in(load_in), .store_in(store_in),
    .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in),
    .rd_out(rd_out), .rd_addr_out(rd_addr_out), .rd_val_out(rd_val_out),
    .stallreq_from_mem(stallreq_from_mem), .misalign_out(misalign_out),
    .ram(ram_if)
  );

  always #5 clk_in = ~clk_in;

  int cycle_ctr = 0;
  always @(posedge clk_in) cycle_ctr <= cycle_ctr + 1;

  // RAM model: registered read, data valid one cycle after its address.
  logic [7:0]  mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_data = 8'd0;
  always @(posedge clk_in) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_if.ram_wr_out) mem[ram_if.ram_addr_out[11:0]] <= ram_if.ram_data_out;
    ram_if.ram_data_in <= mem[ram_if.ram_addr_out[11:0]];
  end

  typedef struct { logic [31:0] a; logic [7:0] d; int c; } wr_t;
  wr_t wlog[$];
  always @(negedge clk_in) if (ram_if.ram_wr_out) wlog.push_back('{ram_if.ram_addr_out, ram_if.ram_data_out, cycle_ctr});

  typedef struct { logic [31:0] val; logic rdo; int cyc; int stalls; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk_in); #1;
    pl_en = 1'b0;
  endtask

  // Drives one memory request (held while stalled) and observes the DONE cycle.
  task automatic do_mem(input bit ld, input inst_type_t t, input logic [31:0] a, input logic [31:0] v,
                        input logic [4:0] rda, input int pause, output int start, output int cyc,
                        output int stalls, output logic [31:0] val, output logic rdo,
                        output logic [4:0] rdao, output logic mis);
    int k;
    start = cycle_ctr; cyc = -1; stalls = 0; val = 32'd0; rdo = 1'b0; rdao = 5'd0; mis = 1'b0;
    load_in = ld; store_in = !ld; inst_type_in = t; mem_addr_in = a; mem_val_in = v;
    rd_in = 1'b1; rd_addr_in = rda; rd_val_in = 32'h5A5A_5A5A; rdy_in = (pause != 0);
    k = 0;
    while (k < 40) begin
      @(negedge clk_in);
      if (!stallreq_from_mem) begin
        cyc = k; val = rd_val_out; rdo = rd_out; rdao = rd_addr_out; mis = misalign_out;
        break;
      end
      stalls++;
      @(posedge clk_in); #1;
      k++;
      rdy_in = (k != pause);
    end
    @(posedge clk_in); #1;
    rdy_in = 1'b1; load_in = 1'b0; store_in = 1'b0; rd_in = 1'b0; rd_addr_in = 5'd0;
    rd_val_in = 32'd0; inst_type_in = INST_ADDI;
  endtask

  task automatic test_reset();
    rd_in = 1'b1; rd_addr_in = 5'd5; rd_val_in = 32'h55;
    #2;
    total++; if (rd_out !== 1'b0) begin bad++; $display("FAIL rst_rd_out got=%b want=0", rd_out); end
    total++; if (rd_addr_out !== 5'd0) begin bad++; $display("FAIL rst_rd_addr got=%0d want=0", rd_addr_out); end
    total++; if (rd_val_out !== 32'd0) begin bad++; $display("FAIL rst_rd_val got=%h want=0", rd_val_out); end
    total++; if (ram_if.ram_wr_out !== 1'b0) begin bad++; $display("FAIL rst_ram_wr got=%b want=0", ram_if.ram_wr_out); end
    total++; if (ram_if.ram_addr_out !== 32'd0) begin bad++; $display("FAIL rst_ram_addr got=%h want=0", ram_if.ram_addr_out); end
    total++; if (ram_if.ram_data_out !== 8'd0) begin bad++; $display("FAIL rst_ram_data got=%h want=0", ram_if.ram_data_out); end
    total++; if (misalign_out !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b want=0", misalign_out); end
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b1; rd_in = 1'b0; rd_addr_in = 5'd0; rd_val_in = 32'd0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_passthrough();
    logic [31:0] vals [3] = '{32'd7, 32'hFFFF_FFFF, 32'hA5A5_0001};
    logic [4:0]  adrs [3] = '{5'd3, 5'd31, 5'd0};
    logic        ens  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      inst_type_in = INST_ADDI; rd_in = ens[i]; rd_addr_in = adrs[i]; rd_val_in = vals[i];
      @(negedge clk_in);
      total++; if (rd_val_out !== vals[i]) begin bad++; $display("FAIL pass_val[%0d] got=%h want=%h", i, rd_val_out, vals[i]); end
      total++; if (rd_addr_out !== adrs[i] || rd_out !== ens[i]) begin bad++; $display("FAIL pass_rd[%0d] got=%b/%0d want=%b/%0d", i, rd_out, rd_addr_out, ens[i], adrs[i]); end
      total++; if (stallreq_from_mem !== 1'b0) begin bad++; $display("FAIL pass_stall[%0d] got=%b want=0", i, stallreq_from_mem); end
      @(posedge clk_in); #1;
    end
    rd_in = 1'b0; rd_addr_in = 5'd0; rd_val_in = 32'd0;
  endtask

  task automatic test_lw();
    int st, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    sb.push_back('{32'h1234_5678, 1'b1, 6, 6});
    do_mem(1'b1, INST_LW, 32'h100, 32'd0, 5'd9, -1, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (v !== e.val) begin bad++; $display("FAIL lw_val got=%h want=%h", v, e.val); end
    total++; if (ro !== e.rdo || ra !== 5'd9) begin bad++; $display("FAIL lw_rd got=%b/%0d want=%b/9", ro, ra, e.rdo); end
    total++; if (cyc !== e.cyc) begin bad++; $display("FAIL lw_done_cycle got=%0d want=%0d", cyc, e.cyc); end
    total++; if (stl !== e.stalls) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=%0d", stl, e.stalls); end
    total++; if (mi !== 1'b0) begin bad++; $display("FAIL lw_misalign got=%b want=0", mi); end
  endtask

  task automatic test_ext();
    inst_type_t  ts [4] = '{INST_LB, INST_LBU, INST_LH, INST_LHU};
    logic [31:0] as [4] = '{32'h200, 32'h200, 32'h210, 32'h210};
    logic [31:0] xs [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    int          cs [4] = '{3, 3, 4, 4};
    int st, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    poke(12'h200, 8'h80); poke(12'h201, 8'h7F); poke(12'h210, 8'h01); poke(12'h211, 8'h80);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{xs[i], 1'b1, cs[i], cs[i]});
      do_mem(1'b1, ts[i], as[i], 32'd0, 5'd1, -1, st, cyc, stl, v, ro, ra, mi);
      e = sb.pop_front();
      total++; if (v !== e.val) begin bad++; $display("FAIL ext_val[%0d] got=%h want=%h", i, v, e.val); end
      total++; if (cyc !== e.cyc || ro !== e.rdo) begin bad++; $display("FAIL ext_done[%0d] got=%0d/%b want=%0d/%b", i, cyc, ro, e.cyc, e.rdo); end
    end
  endtask

  task automatic test_sh();
    int st, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    logic [31:0] wa [2] = '{32'h300, 32'h301};
    logic [7:0]  wd [2] = '{8'hCD, 8'hAB};
    wlog.delete();
    sb.push_back('{32'd0, 1'b0, 3, 3});
    do_mem(1'b0, INST_SH, 32'h300, 32'h0000_ABCD, 5'd4, -1, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (v !== e.val || ro !== e.rdo) begin bad++; $display("FAIL sh_wb got=%h/%b want=%h/%b", v, ro, e.val, e.rdo); end
    total++; if (cyc !== e.cyc || stl !== e.stalls) begin bad++; $display("FAIL sh_timing got=%0d/%0d want=%0d/%0d", cyc, stl, e.cyc, e.stalls); end
    total++; if (wlog.size() !== 2) begin bad++; $display("FAIL sh_write_count got=%0d want=2", wlog.size()); end
    for (int i = 0; i < 2; i++) if (i < wlog.size()) begin
      total++;
      if (wlog[i].a !== wa[i] || wlog[i].d !== wd[i] || wlog[i].c !== st + 1 + i) begin
        bad++; $display("FAIL sh_write[%0d] got=%h/%h@%0d want=%h/%h@%0d", i, wlog[i].a, wlog[i].d, wlog[i].c, wa[i], wd[i], st + 1 + i);
      end
    end
  endtask

  task automatic test_rdy_pause();
    int st, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    logic [31:0] m;
    sb.push_back('{32'h1234_5678, 1'b1, 7, 7});
    do_mem(1'b1, INST_LW, 32'h100, 32'd0, 5'd6, 2, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (v !== e.val) begin bad++; $display("FAIL pause_lw_val got=%h want=%h", v, e.val); end
    total++; if (cyc !== e.cyc || stl !== e.stalls) begin bad++; $display("FAIL pause_lw_timing got=%0d/%0d want=%0d/%0d", cyc, stl, e.cyc, e.stalls); end
    wlog.delete();
    sb.push_back('{32'd0, 1'b0, 6, 6});
    do_mem(1'b0, INST_SW, 32'h700, 32'hDEAD_BEEF, 5'd6, 2, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    m = {mem[12'h703], mem[12'h702], mem[12'h701], mem[12'h700]};
    total++; if (cyc !== e.cyc || ro !== e.rdo) begin bad++; $display("FAIL pause_sw_done got=%0d/%b want=%0d/%b", cyc, ro, e.cyc, e.rdo); end
    total++; if (wlog.size() !== 4) begin bad++; $display("FAIL pause_sw_writes got=%0d want=4", wlog.size()); end
    total++; if (m !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pause_sw_mem got=%h want=deadbeef", m); end
  endtask

  task automatic test_back_to_back();
    int st0, st1, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    sb.push_back('{32'd0, 1'b0, 5, 5});
    do_mem(1'b0, INST_SW, 32'h400, 32'hCAFE_BABE, 5'd2, -1, st0, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (cyc !== e.cyc || stl !== e.stalls) begin bad++; $display("FAIL b2b_sw_timing got=%0d/%0d want=%0d/%0d", cyc, stl, e.cyc, e.stalls); end
    sb.push_back('{32'hCAFE_BABE, 1'b1, 6, 6});
    do_mem(1'b1, INST_LW, 32'h400, 32'd0, 5'd2, -1, st1, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (st1 - st0 !== 6) begin bad++; $display("FAIL b2b_gap got=%0d want=6", st1 - st0); end
    total++; if (v !== e.val || cyc !== e.cyc) begin bad++; $display("FAIL b2b_lw got=%h@%0d want=%h@%0d", v, cyc, e.val, e.cyc); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) poke(12'h500 + 12'(i), 8'hEE);
    wlog.delete();
    load_in = 1'b0; store_in = 1'b1; inst_type_in = INST_SW; mem_addr_in = 32'h500;
    mem_val_in = 32'h1122_3344; rd_in = 1'b1; rd_addr_in = 5'd7;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0; store_in = 1'b0; rd_in = 1'b0; inst_type_in = INST_ADDI;
    #1;
    total++; if (ram_if.ram_wr_out !== 1'b0 || ram_if.ram_addr_out !== 32'd0) begin bad++; $display("FAIL midrst_ram got=%b/%h want=0/0", ram_if.ram_wr_out, ram_if.ram_addr_out); end
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    total++; if (wlog.size() !== 1) begin bad++; $display("FAIL midrst_writes got=%0d want=1", wlog.size()); end
    total++; if (mem[12'h500] !== 8'h44 || mem[12'h501] !== 8'hEE) begin bad++; $display("FAIL midrst_mem got=%h/%h want=44/ee", mem[12'h500], mem[12'h501]); end
    rd_in = 1'b1; rd_addr_in = 5'd2; rd_val_in = 32'h99;
    @(negedge clk_in);
    total++; if (rd_val_out !== 32'h99 || stallreq_from_mem !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%h/%b want=99/0", rd_val_out, stallreq_from_mem); end
    @(posedge clk_in); #1;
    rd_in = 1'b0; rd_addr_in = 5'd0; rd_val_in = 32'd0;
  endtask

  task automatic test_misalign();
    int st, cyc, stl; logic [31:0] v; logic ro, mi; logic [4:0] ra; exp_t e;
    wlog.delete();
`ifdef MEM_ALIGN_CHECK_EN
    sb.push_back('{32'd0, 1'b0, 1, 1});
    do_mem(1'b1, INST_LW, 32'h102, 32'd0, 5'd3, -1, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (mi !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", mi); end
`else
    poke(12'h602, 8'h01); poke(12'h603, 8'h02); poke(12'h604, 8'h03); poke(12'h605, 8'h04);
    sb.push_back('{32'h0403_0201, 1'b1, 6, 6});
    do_mem(1'b1, INST_LW, 32'h602, 32'd0, 5'd3, -1, st, cyc, stl, v, ro, ra, mi);
    e = sb.pop_front();
    total++; if (mi !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b want=0", mi); end
`endif
    total++; if (v !== e.val || ro !== e.rdo) begin bad++; $display("FAIL mis_wb got=%h/%b want=%h/%b", v, ro, e.val, e.rdo); end
    total++; if (cyc !== e.cyc || stl !== e.stalls) begin bad++; $display("FAIL mis_timing got=%0d/%0d want=%0d/%0d", cyc, stl, e.cyc, e.stalls); end
    total++; if (wlog.size() !== 0) begin bad++; $display("FAIL mis_writes got=%0d want=0", wlog.size()); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_ext();
    test_sh();
    test_rdy_pause();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
